// File: rtl/or_window_accumulator.sv
// Purpose: ORs the masked input lanes per sample; registers it per sample (mode 0) or OR-accumulates a window (mode 1).
// Latency: result and res_valid pulse appear 1 cycle after the sample that completes them.
// Backpressure: none; a sample is taken every cycle in_valid is high, unless that cycle is a clear or a mode change.
module or_window_accumulator #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int WINDOW   = 4,
    localparam int CW       = $clog2(WINDOW)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       chan_mask,
    input  logic                      mode,
    input  logic                      clear,
    output logic [WIDTH-1:0]          res,
    output logic                      res_valid,
    output logic                      busy,
    output logic [CW-1:0]             sample_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(WINDOW - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             res_valid_nxt;
    logic             mode_q;
    logic [WIDTH-1:0] sample_or;
    logic             abort;

    // OR of every lane whose mask bit is set; all-zero mask gives zero.
    always_comb begin
        sample_or = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chan_mask[i]) begin
                sample_or = sample_or | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A mode change behaves exactly like clear: the window and the sample are dropped.
    assign abort = clear || (mode != mode_q);

    // Next-state and result logic; priority is abort first, then the sample.
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        res_nxt       = res;
        res_valid_nxt = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
        end else if (in_valid) begin
            if (!mode) begin
                res_nxt       = sample_or;
                res_valid_nxt = 1'b1;
            end else if (cnt == LAST_CNT) begin
                res_nxt       = acc | sample_or;
                res_valid_nxt = 1'b1;
                acc_nxt       = '0;
                cnt_nxt       = '0;
                state_nxt     = IDLE;
            end else begin
                acc_nxt   = acc | sample_or;
                cnt_nxt   = cnt + CW'(1);
                state_nxt = ACCUM;
            end
        end
    end

    // State register; reset discards any partial window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: accumulator, counter, result and the registered mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            res       <= '0;
            res_valid <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            res       <= res_nxt;
            res_valid <= res_valid_nxt;
            mode_q    <= mode;
        end
    end

    assign busy       = (state == ACCUM);
    assign sample_cnt = cnt;

endmodule

// File: tb/tb_or_window_accumulator.sv
// Purpose: directed test-plan sequences plus random traffic checked against a queue-based window model.
// Latency: outputs are compared 1 time unit after each rising edge.
// Backpressure: none; stimulus is applied every cycle.
module tb_or_window_accumulator;

    localparam int W   = 8;
    localparam int CH  = 4;
    localparam int WIN = 4;
    localparam int CW  = $clog2(WIN);

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [CH*W-1:0]   in_data;
    logic [CH-1:0]     chan_mask;
    logic              mode;
    logic              clear;
    logic [W-1:0]      res;
    logic              res_valid;
    logic              busy;
    logic [CW-1:0]     sample_cnt;

    int n_vec;
    int n_err;

    // Reference model state
    logic [W-1:0] win_q[$];
    logic         m_mode_q;
    logic [W-1:0] m_res;
    logic         m_rv;

    or_window_accumulator #(.WIDTH(W), .CHANNELS(CH), .WINDOW(WIN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .chan_mask  (chan_mask),
        .mode       (mode),
        .clear      (clear),
        .res        (res),
        .res_valid  (res_valid),
        .busy       (busy),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] masked_or(input logic [CH*W-1:0] d, input logic [CH-1:0] m);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < CH; i++)
            if (m[i]) r = r | d[i*W +: W];
        return r;
    endfunction

    task automatic model_reset();
        win_q.delete();
        m_mode_q = 1'b0;
        m_res    = '0;
        m_rv     = 1'b0;
    endtask

    // Applies the rules for one rising edge using the inputs present at that edge.
    task automatic model_edge();
        logic [W-1:0] so;
        logic [W-1:0] r;
        so   = masked_or(in_data, chan_mask);
        m_rv = 1'b0;
        if (clear || (mode != m_mode_q)) begin
            win_q.delete();
        end else if (in_valid) begin
            if (!mode) begin
                m_res = so;
                m_rv  = 1'b1;
            end else begin
                win_q.push_back(so);
                if (win_q.size() == WIN) begin
                    r = '0;
                    foreach (win_q[k]) r = r | win_q[k];
                    m_res = r;
                    m_rv  = 1'b1;
                    win_q.delete();
                end
            end
        end
        m_mode_q = mode;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".res"},       32'(res),        32'(m_res));
        check({tag, ".res_valid"}, 32'(res_valid),  32'(m_rv));
        check({tag, ".busy"},      32'(busy),       32'(win_q.size() != 0));
        check({tag, ".cnt"},       32'(sample_cnt), 32'(win_q.size()));
    endtask

    task automatic step(input string tag, input logic v, input logic [CH*W-1:0] d,
                        input logic [CH-1:0] m, input logic md, input logic clr);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        chan_mask = m;
        mode      = md;
        clear     = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; chan_mask = '0; mode = 1'b0; clear = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: per-sample mode, full mask, back-to-back pulses
        step("t1a", 1'b1, 32'h00000000, 4'b1111, 1'b0, 1'b0);
        check("t1a_const", 32'(res), 32'h00);
        step("t1b", 1'b1, 32'h00000001, 4'b1111, 1'b0, 1'b0);
        check("t1b_const", 32'(res), 32'h01);
        step("t1c", 1'b1, 32'h80000200, 4'b1111, 1'b0, 1'b0);
        check("t1c_const", 32'(res), 32'h82);
        step("t1d", 1'b1, 32'hFFFFFFFF, 4'b1111, 1'b0, 1'b0);
        check("t1d_const", {31'd0, res_valid}, 32'd1);

        // 2: partial mask, then all-zero mask still pulses
        step("t2a", 1'b1, 32'h08040201, 4'b0101, 1'b0, 1'b0);
        check("t2a_const", 32'(res), 32'h05);
        step("t2b", 1'b1, 32'h08040201, 4'b0000, 1'b0, 1'b0);
        check("t2b_const", 32'(res), 32'h00);
        check("t2b_valid", {31'd0, res_valid}, 32'd1);

        // 3: windowed mode with a gap inside the window
        step("t3s", 1'b0, 32'h0, 4'b0001, 1'b1, 1'b0);
        step("t3a", 1'b1, 32'h01, 4'b0001, 1'b1, 1'b0);
        step("t3b", 1'b1, 32'h02, 4'b0001, 1'b1, 1'b0);
        step("t3g1", 1'b0, 32'hFF, 4'b0001, 1'b1, 1'b0);
        step("t3g2", 1'b0, 32'hFF, 4'b0001, 1'b1, 1'b0);
        check("t3_cnt_gap", 32'(sample_cnt), 32'd2);
        step("t3c", 1'b1, 32'h00, 4'b0001, 1'b1, 1'b0);
        step("t3d", 1'b1, 32'h10, 4'b0001, 1'b1, 1'b0);
        check("t3_res", 32'(res), 32'h13);
        check("t3_busy", {31'd0, busy}, 32'd0);

        // 4: clear with a simultaneous sample drops both window and sample
        step("t4a", 1'b1, 32'h0F, 4'b0001, 1'b1, 1'b0);
        step("t4b", 1'b1, 32'hF0, 4'b0001, 1'b1, 1'b0);
        step("t4clr", 1'b1, 32'h01, 4'b0001, 1'b1, 1'b1);
        check("t4_res_held", 32'(res), 32'h13);
        for (int i = 0; i < WIN; i++)
            step("t4w", 1'b1, 32'h01, 4'b0001, 1'b1, 1'b0);
        check("t4_res", 32'(res), 32'h01);

        // 5: mode change mid-window discards it
        for (int i = 0; i < 3; i++)
            step("t5w", 1'b1, 32'hFF, 4'b0001, 1'b1, 1'b0);
        step("t5mc", 1'b1, 32'hAA, 4'b0001, 1'b0, 1'b0);
        check("t5_nores", {31'd0, res_valid}, 32'd0);
        step("t5s", 1'b1, 32'h55, 4'b0001, 1'b0, 1'b0);
        check("t5_res", 32'(res), 32'h55);

        // 6: asynchronous reset in the middle of a window
        step("t6s", 1'b0, 32'h0, 4'b0001, 1'b1, 1'b0);
        step("t6a", 1'b1, 32'h03, 4'b0001, 1'b1, 1'b0);
        step("t6b", 1'b1, 32'h03, 4'b0001, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("t6rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("t6s2", 1'b0, 32'h0, 4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < WIN; i++)
            step("t6w", 1'b1, 32'h04, 4'b0001, 1'b1, 1'b0);
        check("t6_res", 32'(res), 32'h04);

        // Random traffic: sparse mode flips and clears, random masks and gaps
        for (int i = 0; i < 400; i++) begin
            logic md;
            md = mode;
            if ($urandom_range(0, 19) == 0) md = ~md;
            step("rnd", 1'($urandom_range(0, 3) != 0), 32'($urandom), 4'($urandom),
                 md, 1'($urandom_range(0, 24) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/or_window_accumulator.md
Name: or_window_accumulator

Overview:
Parametrised, registered successor to the 2-input OR gate. Each valid sample ORs together CHANNELS masked WIDTH-bit lanes. The result is either registered per sample (mode 0) or OR-accumulated over a window of WINDOW samples (mode 1), with a one-cycle result-valid pulse. It is used as a sticky flag/event collector in the datapath labs.

Parameters:
WIDTH, 8, bit width of each channel lane and of the result
CHANNELS, 4, number of input lanes
WINDOW, 4, samples per accumulated result in mode 1; legal range ≥2
CW, $clog2(WINDOW), sample counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data is a valid sample this cycle
in_data  input  CHANNELS*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
chan_mask  input  CHANNELS  1 = lane included in the OR
mode  input  1  0 = per-sample, 1 = windowed accumulate
clear  input  1  synchronous abort of current window
res  output  WIDTH  last produced result
res_valid  output  1  one-cycle pulse when res updates
busy  output  1  1 while a window is partially accumulated
sample_cnt  output  CW  samples taken in the current window

Behaviour:
- sample_or: combinational bitwise OR of every lane with chan_mask[i]=1. Mask all-zero -> sample_or = 0.
- Async reset (rst_n=0): res=0, res_valid=0, acc=0, sample_cnt=0, mode_q=0, state IDLE, busy=0. Reset mid-window discards the partial window.
- States: IDLE (cnt=0, acc=0) and ACCUM (1 ≤ cnt ≤ WINDOW-1). busy = (state==ACCUM).
- Priority per cycle, highest first: clear, then mode change, then in_valid.
- clear=1: acc<=0, cnt<=0, state<=IDLE, res_valid<=0. res holds its value. A simultaneous in_valid sample is dropped.
- mode change: mode_q registers mode every cycle. If mode != mode_q, the cycle behaves as clear, plus mode_q<=mode. The sample is dropped. No result is produced.
- Mode 0, in_valid=1: next edge res<=sample_or, res_valid<=1. Latency 1 cycle. Back-to-back samples give back-to-back pulses. acc and cnt stay 0.
- Mode 1, in_valid=1, cnt < WINDOW-1: acc<=acc|sample_or, cnt<=cnt+1, state<=ACCUM, res_valid<=0.
- Mode 1, in_valid=1, cnt == WINDOW-1: res<=acc|sample_or, res_valid<=1, acc<=0, cnt<=0, state<=IDLE. Result is visible 1 cycle after the last sample.
- in_valid=0: acc, cnt and state hold. Gaps between samples are allowed and do not reset the window. res_valid<=0.
- res_valid is high for exactly one cycle per result. res is stable between results.
- WINDOW samples complete a window regardless of mask changes. Each sample uses the chan_mask value present in its own cycle.

Test Plan:
1. Reset, then mode=0, WIDTH=8, CHANNELS=4, mask=4'b1111, lanes {00,00,00,00}, {01,00,00,00}, {00,02,00,80}, {FF,FF,FF,FF} on consecutive cycles -> res = 00, 01, 82, FF, each 1 cycle after its sample; res_valid high 4 consecutive cycles.
2. Mode 0, mask=4'b0101, lanes {lane0=01, lane1=02, lane2=04, lane3=08} -> res=05. Mask=0 with the same data -> res=00 with res_valid=1.
3. Mode 1, WINDOW=4, single-lane samples 01, 02, 00, 10 with 2 idle cycles between samples 2 and 3 -> no res_valid until 1 cycle after the 4th sample; then res=13, res_valid for 1 cycle, busy=0, sample_cnt=0. During the window busy=1 and sample_cnt steps 1,2,3.
4. Mode 1, 2 samples (0F, F0), then clear together with a valid sample 01 -> sample_cnt=0, busy=0, res unchanged. The next 4 samples of 01 -> res=01 (nothing from before the clear survives).
5. Mode 1, 3 samples taken, then mode->0 with in_valid=1 -> no result that cycle, window discarded. The next mode-0 sample 55 -> res=55 after 1 cycle.
6. Mode 1, 2 samples, rst_n pulsed low asynchronously mid-cycle -> all outputs 0 immediately. After release, a full window of 04 -> res=04.
